// File: rtl/bpi_flash_pkg.sv
// rtl/bpi_flash_pkg.sv - shared types and width helpers for the BPI flash write PHY
//
// Contents:
//   state_e          write sequencer states
//   addr_width()     flash word-address width from byte size and bus width
//   phase_cnt_width() width of the phase counter covering the longest timed phase
package bpi_flash_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_SETUP = 3'd2,
        ST_PULSE = 3'd3,
        ST_HOLD  = 3'd4
    } state_e;

    // Number of word-address bits: log2 of (bits in device / bits per word).
    function automatic int addr_width(input longint mem_size, input int mem_width);
        return $clog2((longint'(8) * mem_size) / longint'(mem_width));
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    // Counter must hold values 0 .. longest_phase-1 without wrapping.
    function automatic int phase_cnt_width(input int setup, input int pulse, input int hold);
        return $clog2(max3(setup, pulse, hold) + 1);
    endfunction

endpackage

// File: rtl/bpi_flash_write_phy.sv
// rtl/bpi_flash_write_phy.sv - single-word BPI parallel-flash write sequencer
//
// Accepts one word per AXIS beat, arbitrates for the shared flash bus, then
// drives an asynchronous write cycle: address/data setup with CE#/ADV# low,
// a WE# low pulse, and a hold period with all strobes released.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   s_axis_wr_tdata/tdest           word to program and its flash word address
//   s_axis_wr_tvalid/tready         AXIS handshake (ready only in IDLE)
//   bus_req / bus_gnt               flash bus arbitration against the read path
//   bpi_a, bpi_dq_o, bpi_dq_t       flash address, write data, tristate (1 = released)
//   bpi_ce_n/we_n/oe_n/adv_n        active-low flash strobes
//   busy                            high whenever the sequencer is not IDLE
module bpi_flash_write_phy
    import bpi_flash_pkg::*;
#(
    parameter int     C_MEM_WIDTH  = 16,
    parameter longint C_MEM_SIZE   = 134217728,
    parameter int     C_ADDR_SETUP = 2,
    parameter int     C_WE_PULSE   = 4,
    parameter int     C_HOLD       = 2,
    localparam int    A            = addr_width(C_MEM_SIZE, C_MEM_WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [C_MEM_WIDTH-1:0] s_axis_wr_tdata,
    input  logic [A-1:0]           s_axis_wr_tdest,
    input  logic                   s_axis_wr_tvalid,
    output logic                   s_axis_wr_tready,
    output logic                   bus_req,
    input  logic                   bus_gnt,
    output logic [A-1:0]           bpi_a,
    output logic [C_MEM_WIDTH-1:0] bpi_dq_o,
    output logic                   bpi_dq_t,
    output logic                   bpi_ce_n,
    output logic                   bpi_we_n,
    output logic                   bpi_oe_n,
    output logic                   bpi_adv_n,
    output logic                   busy
);

    localparam int CW = phase_cnt_width(C_ADDR_SETUP, C_WE_PULSE, C_HOLD);

    localparam logic [CW-1:0] SETUP_LAST = CW'(C_ADDR_SETUP - 1);
    localparam logic [CW-1:0] PULSE_LAST = CW'(C_WE_PULSE - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(C_HOLD - 1);

    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [A-1:0]           addr_q;
    logic [C_MEM_WIDTH-1:0] data_q;
    logic                   accept;

    // Registered pin drivers and their next-state values.
    logic [A-1:0]           a_q, a_d;
    logic [C_MEM_WIDTH-1:0] dq_q, dq_d;
    logic                   dq_t_q, dq_t_d;
    logic                   ce_n_q, ce_n_d;
    logic                   we_n_q, we_n_d;
    logic                   adv_n_q, adv_n_d;
    logic                   bus_req_q, bus_req_d;

    assign s_axis_wr_tready = (state_q == ST_IDLE) & ~rst;
    assign accept           = s_axis_wr_tvalid & s_axis_wr_tready;

    // State register, phase counter and captured write word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q <= s_axis_wr_tdest;
                data_q <= s_axis_wr_tdata;
            end
        end
    end

    // Next-state logic. The counter only advances inside timed phases and is
    // cleared on every transition, so it never exceeds the longest phase - 1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (bus_gnt) state_d = ST_SETUP;
            end
            ST_SETUP: begin
                if (cnt_q == SETUP_LAST) state_d = ST_PULSE;
                else                     cnt_d   = cnt_q + 1'b1;
            end
            ST_PULSE: begin
                if (cnt_q == PULSE_LAST) state_d = ST_HOLD;
                else                     cnt_d   = cnt_q + 1'b1;
            end
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) state_d = ST_IDLE;
                else                    cnt_d   = cnt_q + 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    // Pin values decoded from the next state so that, once registered, they
    // line up exactly with state_q and never glitch.
    always_comb begin
        a_d       = '0;
        dq_d      = '0;
        dq_t_d    = 1'b1;
        ce_n_d    = 1'b1;
        we_n_d    = 1'b1;
        adv_n_d   = 1'b1;
        bus_req_d = 1'b0;
        unique case (state_d)
            ST_IDLE: begin
            end
            ST_REQ: begin
                bus_req_d = 1'b1;
            end
            ST_SETUP: begin
                bus_req_d = 1'b1;
                a_d       = addr_q;
                dq_d      = data_q;
                dq_t_d    = 1'b0;
                ce_n_d    = 1'b0;
                adv_n_d   = 1'b0;
            end
            ST_PULSE: begin
                bus_req_d = 1'b1;
                a_d       = addr_q;
                dq_d      = data_q;
                dq_t_d    = 1'b0;
                ce_n_d    = 1'b0;
                adv_n_d   = 1'b0;
                we_n_d    = 1'b0;
            end
            ST_HOLD: begin
                // Strobes released but address/data still driven for hold time.
                bus_req_d = 1'b1;
                a_d       = addr_q;
                dq_d      = data_q;
                dq_t_d    = 1'b0;
            end
            default: begin
            end
        endcase
    end

    // Output registers; reset forces idle pin values on the same edge, which
    // cuts any WE# pulse in progress short.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q       <= '0;
            dq_q      <= '0;
            dq_t_q    <= 1'b1;
            ce_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
            adv_n_q   <= 1'b1;
            bus_req_q <= 1'b0;
        end else begin
            a_q       <= a_d;
            dq_q      <= dq_d;
            dq_t_q    <= dq_t_d;
            ce_n_q    <= ce_n_d;
            we_n_q    <= we_n_d;
            adv_n_q   <= adv_n_d;
            bus_req_q <= bus_req_d;
        end
    end

    assign bpi_a     = a_q;
    assign bpi_dq_o  = dq_q;
    assign bpi_dq_t  = dq_t_q;
    assign bpi_ce_n  = ce_n_q;
    assign bpi_we_n  = we_n_q;
    assign bpi_adv_n = adv_n_q;
    assign bpi_oe_n  = 1'b1;
    assign bus_req   = bus_req_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bpi_flash_write_phy.sv
// tb/tb_bpi_flash_write_phy.sv - self-checking bench for bpi_flash_write_phy
module tb_bpi_flash_write_phy;

    localparam int AW = 26;
    localparam int DW = 16;
    localparam int S  = 2;
    localparam int P  = 4;
    localparam int H  = 2;
    localparam int TURN = S + P + H + 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vec  = 0;
    int errs = 0;

    // DUT 0: default timing
    logic          rst0 = 1'b1, tvalid0 = 1'b0, gnt0 = 1'b0;
    logic [DW-1:0] tdata0 = '0;
    logic [AW-1:0] tdest0 = '0;
    logic          tready0, req0, dqt0, ce0, we0, oe0, adv0, busy0;
    logic [AW-1:0] a0;
    logic [DW-1:0] dq0;

    // DUT 1: minimum one-cycle phases
    logic          rst1 = 1'b1, tvalid1 = 1'b0, gnt1 = 1'b0;
    logic [DW-1:0] tdata1 = '0;
    logic [AW-1:0] tdest1 = '0;
    logic          tready1, req1, dqt1, ce1, we1, oe1, adv1, busy1;
    logic [AW-1:0] a1;
    logic [DW-1:0] dq1;

    bpi_flash_write_phy #(.C_MEM_WIDTH(DW), .C_MEM_SIZE(134217728),
                          .C_ADDR_SETUP(S), .C_WE_PULSE(P), .C_HOLD(H)) dut0 (
        .clk(clk), .rst(rst0),
        .s_axis_wr_tdata(tdata0), .s_axis_wr_tdest(tdest0),
        .s_axis_wr_tvalid(tvalid0), .s_axis_wr_tready(tready0),
        .bus_req(req0), .bus_gnt(gnt0),
        .bpi_a(a0), .bpi_dq_o(dq0), .bpi_dq_t(dqt0),
        .bpi_ce_n(ce0), .bpi_we_n(we0), .bpi_oe_n(oe0), .bpi_adv_n(adv0),
        .busy(busy0)
    );

    bpi_flash_write_phy #(.C_MEM_WIDTH(DW), .C_MEM_SIZE(134217728),
                          .C_ADDR_SETUP(1), .C_WE_PULSE(1), .C_HOLD(1)) dut1 (
        .clk(clk), .rst(rst1),
        .s_axis_wr_tdata(tdata1), .s_axis_wr_tdest(tdest1),
        .s_axis_wr_tvalid(tvalid1), .s_axis_wr_tready(tready1),
        .bus_req(req1), .bus_gnt(gnt1),
        .bpi_a(a1), .bpi_dq_o(dq1), .bpi_dq_t(dqt1),
        .bpi_ce_n(ce1), .bpi_we_n(we1), .bpi_oe_n(oe1), .bpi_adv_n(adv1),
        .busy(busy1)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard of words expected on the flash pins of DUT 0.
    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;
    wr_t sb[$];

    bit   active   = 0;
    bit   abort    = 0;
    wr_t  cur;
    int   low_cnt  = 0;
    int   pulses   = 0;
    int   we_fall  = 0;

    // Pin monitor for DUT 0: pops a word when the data bus is first driven,
    // then requires address/data to stay put until the bus is released, and
    // measures every WE# pulse not cut short by reset.
    always @(negedge clk) begin
        if (!rst0) check("oe_n_high", oe0, 1'b1);
        if (dqt0 === 1'b0) begin
            if (!active) begin
                active = 1;
                if (sb.size() == 0) begin
                    check("sb_underflow", sb.size(), 1);
                end else begin
                    cur = sb.pop_front();
                    check("setup_addr", a0, cur.a);
                    check("setup_data", dq0, cur.d);
                end
            end else begin
                check("stable_addr", a0, cur.a);
                check("stable_data", dq0, cur.d);
            end
            check("bus_req_active", req0, 1'b1);
        end else begin
            active = 0;
        end
        if (we0 === 1'b0) begin
            if (low_cnt == 0) begin
                pulses++;
                we_fall = cyc;
            end
            low_cnt++;
            if (rst0) abort = 1;
        end else if (low_cnt != 0) begin
            if (!abort) check("we_width", low_cnt, P);
            low_cnt = 0;
            abort   = 0;
        end
    end

    task automatic send0(input logic [AW-1:0] a, input logic [DW-1:0] d, output int t);
        int n;
        @(posedge clk); #1;
        tdest0 = a; tdata0 = d; tvalid0 = 1'b1;
        n = 0;
        @(negedge clk);
        while (!tready0 && n < 200) begin n++; @(negedge clk); end
        if (n >= 200) check("accept_timeout", n, 0);
        t = cyc;
        sb.push_back('{a: a, d: d});
        @(posedge clk); #1;
        tvalid0 = 1'b0;
    endtask

    task automatic wait_ready0(output int t);
        int n;
        n = 0;
        @(negedge clk);
        while (!tready0 && n < 200) begin n++; @(negedge clk); end
        if (n >= 200) check("ready_timeout", n, 0);
        t = cyc;
    endtask

    initial begin
        int t, tr, p0;
        int acc[3];
        logic [AW-1:0] wa[3];
        logic [DW-1:0] wd[3];
        // {tready, ce_n, we_n, adv_n, dq_t, bus_req} per cycle after accept
        logic [5:0] exp1[5];
        logic       drv1[5];

        exp1[0] = 6'b0_1_1_1_1_1; drv1[0] = 1'b0;
        exp1[1] = 6'b0_0_1_0_0_1; drv1[1] = 1'b1;
        exp1[2] = 6'b0_0_0_0_0_1; drv1[2] = 1'b1;
        exp1[3] = 6'b0_1_1_1_0_1; drv1[3] = 1'b1;
        exp1[4] = 6'b1_1_1_1_1_0; drv1[4] = 1'b0;
        wa[0] = 26'h0000010; wd[0] = 16'h1111;
        wa[1] = 26'h0000020; wd[1] = 16'h2222;
        wa[2] = 26'h0000030; wd[2] = 16'h3333;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tready", tready0, 1'b0);
        check("rst_bus_req", req0, 1'b0);
        check("rst_busy", busy0, 1'b0);
        check("rst_addr", a0, '0);
        check("rst_dq", dq0, '0);
        check("rst_strobes", {dqt0, ce0, we0, oe0, adv0}, 5'h1F);
        check("rst1_strobes", {tready1, req1, busy1, dqt1, ce1, we1, oe1, adv1}, 8'h1F);
        @(posedge clk); #1;
        rst0 = 1'b0; rst1 = 1'b0;
        @(negedge clk);
        check("idle_tready", tready0, 1'b1);

        // Single write, grant already high
        gnt0 = 1'b1;
        p0 = pulses;
        send0(26'h0000123, 16'hA5A5, t);
        wait_ready0(tr);
        check("t1_tready_return", tr - t, TURN);
        check("t1_we_fall", we_fall - t, 2 + S);
        check("t1_pulses", pulses - p0, 1);

        // Grant withheld for 20 cycles
        gnt0 = 1'b0;
        p0 = pulses;
        send0(26'h3000001, 16'h0F0F, t);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("gnt_wait_strobes", {ce0, we0, adv0, dqt0}, 4'hF);
            check("gnt_wait_req", req0, 1'b1);
        end
        @(posedge clk); #1;
        gnt0 = 1'b1;
        wait_ready0(tr);
        check("t2_pulses", pulses - p0, 1);

        // Three back-to-back words with tvalid held high
        p0 = pulses;
        @(posedge clk); #1;
        tdest0 = wa[0]; tdata0 = wd[0]; tvalid0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            int n;
            n = 0;
            @(negedge clk);
            while (!tready0 && n < 200) begin n++; @(negedge clk); end
            if (n >= 200) check("b2b_timeout", n, 0);
            acc[i] = cyc;
            sb.push_back('{a: wa[i], d: wd[i]});
            @(posedge clk); #1;
            if (i < 2) begin
                tdest0 = wa[i+1]; tdata0 = wd[i+1];
            end else begin
                tvalid0 = 1'b0;
            end
        end
        wait_ready0(tr);
        check("b2b_gap1", acc[1] - acc[0], TURN);
        check("b2b_gap2", acc[2] - acc[1], TURN);
        check("b2b_pulses", pulses - p0, 3);

        // Reset during the second PULSE cycle
        p0 = pulses;
        send0(26'h2ABCDEF, 16'h1234, t);
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (we0 !== 1'b0 && n < 100) begin n++; @(negedge clk); end
            if (n >= 100) check("pulse_timeout", n, 0);
        end
        @(posedge clk); #1;
        rst0 = 1'b1;
        @(posedge clk); #1;
        check("abort_we_n", we0, 1'b1);
        check("abort_dq_t", dqt0, 1'b1);
        check("abort_bus_req", req0, 1'b0);
        check("abort_busy", busy0, 1'b0);
        check("abort_tready", tready0, 1'b0);
        rst0 = 1'b0;
        send0(26'h0000155, 16'hBEEF, t);
        wait_ready0(tr);
        check("post_abort_return", tr - t, TURN);
        check("post_abort_pulses", pulses - p0, 2);

        // One-cycle phases, all-ones address, two consecutive writes
        gnt1 = 1'b1;
        for (int w = 0; w < 2; w++) begin
            int n;
            @(posedge clk); #1;
            tdest1 = '1; tdata1 = 16'h5A5A ^ DW'(w); tvalid1 = 1'b1;
            n = 0;
            @(negedge clk);
            while (!tready1 && n < 100) begin n++; @(negedge clk); end
            if (n >= 100) check("p1_accept_timeout", n, 0);
            @(posedge clk); #1;
            tvalid1 = 1'b0;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                check("p1_strobes", {tready1, ce1, we1, adv1, dqt1, req1}, exp1[i]);
                check("p1_addr", a1, drv1[i] ? {AW{1'b1}} : {AW{1'b0}});
                check("p1_data", dq1, drv1[i] ? (16'h5A5A ^ DW'(w)) : 16'h0000);
            end
        end

        repeat (2) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
